// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fixed-priority D/F arbiter for a single-ported data memory with starvation guard and D lock
module dmem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  input  logic              i_d_lock,
  input  logic              i_f_req,
  input  logic              i_f_we,
  input  logic [ADDR_W-1:0] i_f_addr,
  input  logic [DATA_W-1:0] i_f_wdata,
  output logic              o_d_gnt,
  output logic              o_f_gnt,
  output logic              o_d_rvalid,
  output logic              o_f_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam logic [3:0] MAX = 4'(MAX_STREAK);
  logic [3:0]        r_streak;
  logic              r_lock;
  logic              r_d_rvalid;
  logic              r_f_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              w_starved;
  logic              w_d_gnt;
  logic              w_f_gnt;
  logic              w_we;
  always_comb begin
    w_starved   = i_f_req && r_streak == MAX;
    w_d_gnt     = rst_n && i_d_req && (r_lock || !w_starved);
    w_f_gnt     = rst_n && !r_lock && i_f_req && (w_starved || !i_d_req);
    w_we        = w_d_gnt ? i_d_we : i_f_we;
    o_mem_addr  = w_d_gnt ? i_d_addr : w_f_gnt ? i_f_addr : '0;
    o_mem_wdata = w_d_gnt ? i_d_wdata : w_f_gnt ? i_f_wdata : '0;
    o_mem_write = (w_d_gnt || w_f_gnt) && w_we;
    o_mem_read  = (w_d_gnt || w_f_gnt) && !w_we;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak   <= '0;
      r_lock     <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_f_rvalid <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_lock     <= w_d_gnt && i_d_lock;
      r_streak   <= (w_f_gnt || !i_f_req) ? 4'd0 : (w_d_gnt && r_streak < MAX) ? r_streak + 4'd1 : r_streak;
      r_d_rvalid <= w_d_gnt && !i_d_we;
      r_f_rvalid <= w_f_gnt && !i_f_we;
      if (o_mem_read) r_rdata <= i_mem_rdata;
    end
  end
  assign o_d_gnt    = w_d_gnt;
  assign o_f_gnt    = w_f_gnt;
  assign o_d_rvalid = r_d_rvalid;
  assign o_f_rvalid = r_f_rvalid;
  assign o_rdata    = r_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven directed check of dmem_arbiter against a behavioural 64-word memory
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0, f_req = 1'b0, f_we = 1'b0;
  logic [5:0]  d_addr = '0, f_addr = '0;
  logic [31:0] d_wdata = '0, f_wdata = '0;
  logic        d_gnt, f_gnt, d_rvalid, f_rvalid, mem_read, mem_write;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [5:0]  mem_addr;
  logic [31:0] mem [64];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_lock(d_lock),
    .i_f_req(f_req), .i_f_we(f_we), .i_f_addr(f_addr), .i_f_wdata(f_wdata),
    .o_d_gnt(d_gnt), .o_f_gnt(f_gnt), .o_d_rvalid(d_rvalid), .o_f_rvalid(f_rvalid),
    .o_rdata(rdata), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic dr, dw; logic [5:0] da; logic [31:0] dd; logic dl;
    logic fr, fw; logic [5:0] fa; logic [31:0] fd;
    logic gd, gf, rd, wr; logic [5:0] ea; logic [31:0] ewd;
    logic dv, fv; logic [31:0] erd;
  } vec_t;
  vec_t v [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    d_req = x.dr; d_we = x.dw; d_addr = x.da; d_wdata = x.dd; d_lock = x.dl;
    f_req = x.fr; f_we = x.fw; f_addr = x.fa; f_wdata = x.fd;
  endtask

  task automatic idle_inputs();
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_lock = 0;
    f_req = 0; f_we = 0; f_addr = 0; f_wdata = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[1] = 32'd9;
    mem[2] = 32'd25;
    //          dr dw da dd         dl fr fw fa fd            gd gf rd wr ea ewd           dv fv erd
    v[0]  = '{1, 0, 1, 0,          0, 0, 0, 0, 0,            1, 0, 1, 0, 1, 0,            0, 0, 0};
    v[1]  = '{0, 0, 0, 0,          0, 1, 1, 5, 32'hDEADBEEF, 0, 1, 0, 1, 5, 32'hDEADBEEF, 1, 0, 9};
    v[2]  = '{0, 0, 0, 0,          0, 1, 0, 5, 0,            0, 1, 1, 0, 5, 0,            0, 0, 9};
    v[3]  = '{0, 0, 0, 0,          0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 1, 32'hDEADBEEF};
    v[4]  = '{1, 0, 2, 0,          0, 1, 0, 1, 0,            1, 0, 1, 0, 2, 0,            0, 0, 32'hDEADBEEF};
    v[5]  = '{1, 0, 2, 0,          0, 1, 0, 1, 0,            1, 0, 1, 0, 2, 0,            1, 0, 25};
    v[6]  = '{1, 0, 2, 0,          0, 1, 0, 1, 0,            1, 0, 1, 0, 2, 0,            1, 0, 25};
    v[7]  = '{1, 0, 2, 0,          0, 1, 0, 1, 0,            1, 0, 1, 0, 2, 0,            1, 0, 25};
    v[8]  = '{1, 0, 2, 0,          0, 1, 0, 1, 0,            0, 1, 1, 0, 1, 0,            1, 0, 25};
    v[9]  = '{1, 0, 2, 0,          0, 1, 0, 1, 0,            1, 0, 1, 0, 2, 0,            0, 1, 9};
    v[10] = '{1, 0, 2, 0,          0, 1, 0, 1, 0,            1, 0, 1, 0, 2, 0,            1, 0, 25};
    v[11] = '{1, 0, 2, 0,          0, 1, 0, 1, 0,            1, 0, 1, 0, 2, 0,            1, 0, 25};
    v[12] = '{1, 0, 2, 0,          0, 1, 0, 1, 0,            1, 0, 1, 0, 2, 0,            1, 0, 25};
    v[13] = '{1, 0, 2, 0,          0, 1, 0, 1, 0,            0, 1, 1, 0, 1, 0,            1, 0, 25};
    v[14] = '{1, 0, 1, 0,          1, 1, 0, 2, 0,            1, 0, 1, 0, 1, 0,            0, 1, 9};
    v[15] = '{0, 0, 0, 0,          0, 1, 0, 2, 0,            0, 0, 0, 0, 0, 0,            1, 0, 9};
    v[16] = '{0, 0, 0, 0,          0, 1, 0, 2, 0,            0, 1, 1, 0, 2, 0,            0, 0, 9};
    v[17] = '{0, 0, 0, 0,          0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 1, 25};
    v[18] = '{1, 1, 3, 32'h77,     0, 0, 0, 0, 0,            1, 0, 0, 1, 3, 32'h77,       0, 0, 25};
    v[19] = '{1, 0, 3, 0,          0, 0, 0, 0, 0,            1, 0, 1, 0, 3, 0,            0, 0, 25};
    v[20] = '{0, 0, 0, 0,          0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0,            1, 0, 32'h77};

    // requests asserted during reset must not be granted
    d_req = 1; d_addr = 1; f_req = 1;
    #1;
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_f_gnt", 32'(f_gnt), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_rvalid", {30'd0, d_rvalid, f_rvalid}, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 21; i++) begin
      drive(v[i]);
      #1;
      chk($sformatf("v%0d_d_gnt", i), 32'(d_gnt), 32'(v[i].gd));
      chk($sformatf("v%0d_f_gnt", i), 32'(f_gnt), 32'(v[i].gf));
      chk($sformatf("v%0d_mem_read", i), 32'(mem_read), 32'(v[i].rd));
      chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(v[i].wr));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(v[i].ea));
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v[i].ewd);
      chk($sformatf("v%0d_d_rvalid", i), 32'(d_rvalid), 32'(v[i].dv));
      chk($sformatf("v%0d_f_rvalid", i), 32'(f_rvalid), 32'(v[i].fv));
      chk($sformatf("v%0d_rdata", i), rdata, v[i].erd);
      @(negedge clk);
    end

    // ten idle cycles: memory bus quiet, rdata holds
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("idle%0d_mem_rw", i), {30'd0, mem_read, mem_write}, 0);
      chk($sformatf("idle%0d_mem_addr", i), 32'(mem_addr), 0);
      chk($sformatf("idle%0d_rvalid", i), {30'd0, d_rvalid, f_rvalid}, 0);
      chk($sformatf("idle%0d_rdata", i), rdata, 32'h77);
      @(negedge clk);
    end

    // reset lands while a D read is granted
    d_req = 1; d_addr = 2;
    #1;
    chk("mr_gnt_before", 32'(d_gnt), 1);
    #1 rst_n = 0;
    #1;
    chk("mr_gnt_in_rst", 32'(d_gnt), 0);
    chk("mr_mem_read_in_rst", 32'(mem_read), 0);
    chk("mr_rdata_in_rst", rdata, 0);
    @(negedge clk);
    #1;
    chk("mr_d_rvalid_after_edge", 32'(d_rvalid), 0);
    chk("mr_rdata_after_edge", rdata, 0);
    chk("mr_gnt_held_rst", 32'(d_gnt), 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("mr_gnt_after_release", 32'(d_gnt), 1);
    chk("mr_addr_after_release", 32'(mem_addr), 2);
    chk("mr_rvalid_after_release", 32'(d_rvalid), 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("mr_first_rvalid", 32'(d_rvalid), 1);
    chk("mr_first_rdata", rdata, 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
